clk_switch_ctrl: RTL and testbench

- Control stage directly upstream of the glitch-free clock mux; generates the mux `select` level (1 = clk1, 0 = clk2).
- Runs on clk1 and monitors clk2 liveness.
- Switches to clk2 only after clk2 has been proven active, and fails over to clk1 automatically if clk2 stops while selected.
- Exposes busy/status/sticky-fail to the clock-management register block.

---
 rtl/clk_switch_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clk_switch_ctrl
//
// Control stage in front of a glitch-free clock mux. Runs on clk1, watches clk2
// for activity, and drives the mux select level (1 = clk1, 0 = clk2). A switch
// to clk2 is only made after a full measurement window has shown clk2 toggling.
// If clk2 stops while selected, the block fails over to clk1 on its own and
// raises a sticky fail flag for the clock-management register block.
//
// Ports:
//   clk1      in   control clock, always running
//   rstn      in   asynchronous active-low reset, clears both clock domains
//   clk2      in   monitored clock, only clocks the activity toggle flop
//   req_clk2  in   level request: 1 = run on clk2, 0 = run on clk1
//   fail_clr  in   single-cycle pulse that clears fail (a same-cycle set wins)
//   select    out  registered mux select, 1 = clk1
//   busy      out  high while checking or settling a switch
//   clk2_ok   out  verdict of the most recent completed liveness window
//   fail      out  sticky: failed check or failover
// -----------------------------------------------------------------------------
module clk_switch_ctrl #(
    parameter int WIN_CYCLES    = 64,
    parameter int MIN_EDGES     = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk1,
    input  logic rstn,
    input  logic clk2,
    input  logic req_clk2,
    input  logic fail_clr,
    output logic select,
    output logic busy,
    output logic clk2_ok,
    output logic fail
);

    localparam int WW = $clog2(WIN_CYCLES);
    localparam int EW = $clog2(MIN_EDGES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES);

    localparam logic [WW-1:0] WIN_LAST    = WW'(WIN_CYCLES - 1);
    localparam logic [EW-1:0] EDGE_MIN    = EW'(MIN_EDGES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_CLK1  = 3'd0,
        S_CHECK = 3'd1,
        S_SW2   = 3'd2,
        S_CLK2  = 3'd3,
        S_SW1   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             tog_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [WW-1:0]    win_q, win_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             ok_q, ok_d;
    logic             fail_q, fail_d;
    logic             select_q, select_d;
    logic             fail_set;
    logic             clk2_edge;
    logic             win_end;
    logic             edges_ok;
    logic             settle_done;
    logic             check_entry;

    // ---------------------------------------------------------------- clk2 side
    // The only clk2-domain flop: it inverts on every clk2 edge so that activity
    // can be carried into clk1 as a slowly changing level.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            tog_q <= 1'b0;
        end else begin
            // NOTE: clocked processes use non-blocking assignments so every flop
            // samples the pre-edge value of the others, independent of order.
            tog_q <= ~tog_q;
        end
    end

    // ---------------------------------------------------------------- clk1 side
    // Synchroniser chain; a difference between the last two stages marks one
    // toggle of the clk2 flop arriving in the clk1 domain.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_q};
        end
    end

    assign clk2_edge   = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
    assign win_end     = (win_q == WIN_LAST);
    assign edges_ok    = (edge_q >= EDGE_MIN);
    assign settle_done = (settle_q == SETTLE_LAST);
    assign check_entry = (state_d == S_CHECK) && (state_q != S_CHECK);

    // Window and edge counters. Entering S_CHECK restarts both so the switch
    // decision is always based on one complete, fresh window.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through this
        // block leaves it unassigned and no latch is inferred.
        win_d  = win_end ? '0 : win_q + 1'b1;
        edge_d = edge_q;
        ok_d   = ok_q;

        if (win_end) begin
            ok_d   = edges_ok;
            // A transition in the window-end cycle opens the next window.
            edge_d = clk2_edge ? EW'(1) : '0;
        end else if (clk2_edge && (edge_q < EDGE_MIN)) begin
            edge_d = edge_q + 1'b1;
        end

        if (check_entry) begin
            win_d  = '0;
            edge_d = '0;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_CLK1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fail_set = 1'b0;
        case (state_q)
            S_CLK1: begin
                // A sticky fail blocks new attempts until software clears it.
                if (req_clk2 && !fail_q) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!req_clk2) begin
                    state_d = S_CLK1;
                end else if (win_end) begin
                    if (edges_ok) begin
                        state_d = S_SW2;
                    end else begin
                        state_d  = S_CLK1;
                        fail_set = 1'b1;
                    end
                end
            end
            S_SW2: begin
                if (settle_done) begin
                    state_d = S_CLK2;
                end
            end
            S_CLK2: begin
                // Failover is tested first so a coincident request drop still
                // records the dead clock.
                if (win_end && !edges_ok) begin
                    state_d  = S_SW1;
                    fail_set = 1'b1;
                end else if (!req_clk2) begin
                    state_d = S_SW1;
                end
            end
            S_SW1: begin
                if (settle_done) begin
                    state_d = S_CLK1;
                end
            end
            default: begin
                state_d = S_CLK1;
            end
        endcase
    end

    // select is decoded from the next state and registered, so the pin has no
    // combinational path from any input and changes together with the state.
    always_comb begin
        select_d = !((state_d == S_SW2) || (state_d == S_CLK2));
        busy     = (state_q == S_CHECK) || (state_q == S_SW2) || (state_q == S_SW1);
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        settle_d = '0;
        if (((state_q == S_SW2) || (state_q == S_SW1)) && (state_d == state_q)) begin
            settle_d = settle_q + 1'b1;
        end

        fail_d = fail_q;
        if (fail_set) begin
            fail_d = 1'b1;
        end else if (fail_clr) begin
            fail_d = 1'b0;
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            win_q    <= '0;
            edge_q   <= '0;
            settle_q <= '0;
            ok_q     <= 1'b0;
            fail_q   <= 1'b0;
            select_q <= 1'b1;
        end else begin
            win_q    <= win_d;
            edge_q   <= edge_d;
            settle_q <= settle_d;
            ok_q     <= ok_d;
            fail_q   <= fail_d;
            select_q <= select_d;
        end
    end

    assign select  = select_q;
    assign clk2_ok = ok_q;
    assign fail    = fail_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_switch_ctrl
//
// Self-checking bench for clk_switch_ctrl. clk1 runs at 100 MHz; clk2 either
// free-runs at 25 MHz, is held low, or emits single counted pulses so that the
// number of transitions per window is exact. Expected output vectors
// {select, busy, clk2_ok, fail} are queued when stimulus is applied and popped
// at the cycle the DUT should show them. Outputs are sampled on negedge clk1.
// -----------------------------------------------------------------------------
module tb_clk_switch_ctrl;

    localparam logic [3:0] M_SEL  = 4'b1000;
    localparam logic [3:0] M_BUSY = 4'b0100;
    localparam logic [3:0] M_OK   = 4'b0010;
    localparam logic [3:0] M_FAIL = 4'b0001;
    localparam logic [3:0] M_ALL  = 4'b1111;

    typedef struct {
        string      tag;
        logic [3:0] mask;
        logic [3:0] val;
    } exp_t;

    logic clk1     = 1'b0;
    logic clk2     = 1'b0;
    logic rstn     = 1'b0;
    logic req_clk2 = 1'b0;
    logic fail_clr = 1'b0;
    logic select;
    logic busy;
    logic clk2_ok;
    logic fail;

    int   total = 0;
    int   bad   = 0;
    bit   clk2_run   = 1'b1;
    int   pulse_req  = 0;
    int   pulse_done = 0;
    exp_t sb_q[$];
    string out_name [4] = '{"select", "busy", "clk2_ok", "fail"};

    clk_switch_ctrl #(
        .WIN_CYCLES   (64),
        .MIN_EDGES    (4),
        .SETTLE_CYCLES(8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk1    (clk1),
        .rstn    (rstn),
        .clk2    (clk2),
        .req_clk2(req_clk2),
        .fail_clr(fail_clr),
        .select  (select),
        .busy    (busy),
        .clk2_ok (clk2_ok),
        .fail    (fail)
    );

    initial forever #5 clk1 = ~clk1;

    // clk2: free-running 25 MHz, or idle low emitting one pulse per request.
    initial begin
        forever begin
            if (clk2_run) begin
                #20 clk2 = ~clk2;
            end else if (pulse_done != pulse_req) begin
                #10 clk2 = 1'b1;
                #10 clk2 = 1'b0;
                pulse_done++;
            end else begin
                clk2 = 1'b0;
                #1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] mask, input logic [3:0] val);
        exp_t e;
        e.tag  = tag;
        e.mask = mask;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t       e;
        logic [3:0] obs;
        e   = sb_q.pop_front();
        obs = {select, busy, clk2_ok, fail};
        for (int i = 0; i < 4; i++) begin
            if (e.mask[3-i]) begin
                check({e.tag, ".", out_name[i]}, obs[3-i], e.val[3-i]);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk1);
    endtask

    initial begin
        logic hold_ok;
        int   n;

        // ---- reset
        expect_out("rst", M_ALL, 4'b1000);
        expect_out("rst_rel", M_ALL, 4'b1000);
        tick(3);
        compare_out();
        rstn = 1'b1;
        tick(2);
        compare_out();

        // ---- 1: clean switch to a running clk2
        req_clk2 = 1'b1;
        expect_out("t1_enter", M_SEL | M_BUSY, 4'b1100);
        expect_out("t1_pre", M_SEL | M_BUSY | M_OK, 4'b1100);
        expect_out("t1_sw", M_ALL, 4'b0110);
        expect_out("t1_settle", M_SEL | M_BUSY, 4'b0100);
        expect_out("t1_run", M_ALL, 4'b0010);
        tick(1);  compare_out();
        tick(63); compare_out();
        tick(1);  compare_out();
        tick(7);  compare_out();
        tick(1);  compare_out();

        // ---- 4: voluntary return, request wiggles ignored during settle
        req_clk2 = 1'b0;
        expect_out("t4_sw1", M_SEL | M_BUSY, 4'b1100);
        expect_out("t4_clk1", M_SEL | M_BUSY | M_FAIL, 4'b1000);
        expect_out("t4_recheck", M_SEL | M_BUSY, 4'b1100);
        expect_out("t4_sw2", M_SEL | M_BUSY, 4'b0100);
        tick(1);
        compare_out();
        hold_ok = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            hold_ok &= (select === 1'b1) && (busy === 1'b1);
            if (i == 1) req_clk2 = 1'b1;
            if (i == 2) req_clk2 = 1'b0;
            if (i == 3) req_clk2 = 1'b1;
        end
        check("t4_sw1_hold", hold_ok, 1'b1);
        tick(1);  compare_out();
        tick(1);  compare_out();
        tick(64); compare_out();

        // ---- 5: asynchronous reset while in S_SW2
        tick(2);
        #2 rstn = 1'b0;
        expect_out("t5_async", M_ALL, 4'b1000);
        #1 compare_out();
        req_clk2 = 1'b0;
        tick(2);
        rstn = 1'b1;
        expect_out("t5_idle", M_ALL, 4'b1000);
        tick(5);
        compare_out();
        req_clk2 = 1'b1;
        expect_out("t5_check", M_SEL | M_BUSY, 4'b1100);
        expect_out("t5_sw2", M_SEL | M_BUSY, 4'b0100);
        expect_out("t5_run", M_ALL, 4'b0010);
        tick(1);  compare_out();
        tick(64); compare_out();
        tick(8);  compare_out();

        // ---- 3: clk2 stops while selected -> failover
        clk2_run = 1'b0;
        expect_out("t3_failover", M_ALL, 4'b1101);
        expect_out("t3_settle", M_SEL | M_BUSY, 4'b1100);
        expect_out("t3_clk1", M_ALL, 4'b1001);
        n = 0;
        while (select !== 1'b1 && n < 130) begin
            tick(1);
            n++;
        end
        compare_out();
        tick(7); compare_out();
        tick(1); compare_out();

        // ---- 2: sticky fail blocks requests; clr restarts a check that fails
        expect_out("t2_ignore", M_SEL | M_BUSY | M_FAIL, 4'b1001);
        expect_out("t2_ignore2", M_SEL | M_BUSY | M_FAIL, 4'b1001);
        tick(4);
        compare_out();
        req_clk2 = 1'b0;
        tick(2);
        req_clk2 = 1'b1;
        tick(4);
        compare_out();
        fail_clr = 1'b1;
        expect_out("t2_clr", M_SEL | M_BUSY | M_FAIL, 4'b1000);
        expect_out("t2_check", M_SEL | M_BUSY, 4'b1100);
        expect_out("t2_fail", M_ALL, 4'b1001);
        tick(1);
        fail_clr = 1'b0;
        compare_out();
        tick(1);
        compare_out();
        hold_ok = 1'b1;
        for (int i = 0; i < 63; i++) begin
            tick(1);
            hold_ok &= (select === 1'b1);
        end
        tick(1);
        hold_ok &= (select === 1'b1);
        check("t2_sel_held", hold_ok, 1'b1);
        compare_out();

        req_clk2 = 1'b0;
        fail_clr = 1'b1;
        expect_out("t2_cleared", M_FAIL, 4'b0000);
        tick(1);
        fail_clr = 1'b0;
        compare_out();

        // ---- 6: exactly 4 transitions pass, exactly 3 fail over; clr loses
        req_clk2 = 1'b1;
        expect_out("t6_check", M_SEL | M_BUSY, 4'b1100);
        expect_out("t6_4edges_sw", M_ALL, 4'b0110);
        expect_out("t6_run", M_SEL | M_BUSY, 4'b0000);
        expect_out("t6_3edges_pre", M_SEL, 4'b0000);
        expect_out("t6_3edges_fo", M_ALL, 4'b1101);
        tick(1);
        compare_out();                              // E
        tick(7);
        for (int i = 0; i < 4; i++) begin           // pulses at E+7..E+31
            pulse_req++;
            if (i < 3) tick(8);
        end
        tick(32);                                   // E+63
        tick(1);                                    // E+64
        compare_out();
        tick(8);                                    // E+72
        compare_out();
        tick(7);
        for (int i = 0; i < 3; i++) begin           // pulses at E+79..E+95
            pulse_req++;
            if (i < 2) tick(8);
        end
        tick(32);                                   // E+127
        compare_out();
        fail_clr = 1'b1;
        tick(1);                                    // E+128: failover edge
        compare_out();
        fail_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
